actuator_stream_ctrl: RTL and testbench



---
 rtl/actuator_stream_ctrl_pkg.sv | 23 ++
 rtl/actuator_stream_ctrl_tile.sv | 45 ++++
 rtl/actuator_stream_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_actuator_stream_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/actuator_stream_ctrl_pkg.sv
// Shared types and constants for the actuator streamer tiling controller.
// Channel order is fixed: in_r, in_i, out_r, out_i.
package actuator_package;

  localparam int NCH      = 4;
  localparam int CH_IN_R  = 0;
  localparam int CH_IN_I  = 1;
  localparam int CH_OUT_R = 2;
  localparam int CH_OUT_I = 3;
  localparam int ADDR_W   = 32;

  typedef logic [NCH-1:0][ADDR_W-1:0] ch_addr_arr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/actuator_stream_ctrl_tile.sv
// Remaining-word counter for one job: yields min(remaining, TILE_LEN)
// and flags when the current tile is the last one.
module actuator_tile_counter #(
  parameter int LW       = 16,
  parameter int TILE_LEN = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic [LW-1:0] len_i,
  input  logic          sub_i,
  input  logic [LW-1:0] sub_len_i,
  output logic [LW-1:0] tile_len_o,
  output logic          last_tile_o
);

  localparam logic [LW-1:0] TILE_MAX = LW'(TILE_LEN);

  logic [LW-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (clear_i) begin
      rem_d = '0;
    end else if (load_i) begin
      rem_d = len_i;
    end else if (sub_i) begin
      rem_d = rem_q - sub_len_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  // The last tile consumes everything left, so the post-subtract count is zero.
  assign tile_len_o  = (rem_q > TILE_MAX) ? TILE_MAX : rem_q;
  assign last_tile_o = (rem_q <= TILE_MAX);

endmodule

// File: rtl/actuator_stream_ctrl.sv
// Tiling controller: splits a job into tiles and drives four streamer channels.
// Define ACTUATOR_STREAM_CTRL_PERF_EN to add busy/stall performance counters.
module actuator_stream_ctrl
  import actuator_package::*;
#(
  parameter int AW       = 32,
  parameter int LW       = 16,
  parameter int TILE_LEN = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [LW-1:0]     len_i,
  input  logic [NCH*AW-1:0] base_addr_i,
  input  logic [NCH-1:0]    ready_start_i,
  input  logic [NCH-1:0]    done_i,
  output logic [NCH-1:0]    req_start_o,
  output logic [NCH*AW-1:0] addr_o,
  output logic [LW-1:0]     tile_len_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              streamer_clear_o,
  output logic [2:0]        dbg_state_o
`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles_o,
  output logic [31:0]       perf_stall_cycles_o
`endif
);

  // Handshake: req_start_o pulses for exactly one cycle, only in ISSUE and only
  // when every ready_start_i bit is high; each done_i bit is a one-cycle pulse
  // that counts only while in WAIT.

  ctrl_state_t              state_q, state_d;
  logic [NCH-1:0]           mask_q, mask_d;
  logic [LW-1:0]            tile_len_q, tile_len_d;
  logic [NCH-1:0][AW-1:0]   addr_q, addr_d;
  logic                     sclr_q, sclr_d;
  logic                     start_acc;
  logic                     tc_sub;
  logic [LW-1:0]            tc_tile_len;
  logic                     tc_last;

  assign start_acc = (state_q == ST_IDLE) && start_i && !clear_i;
  assign tc_sub    = (state_q == ST_NEXT) && !clear_i;

  actuator_tile_counter #(
    .LW       (LW),
    .TILE_LEN (TILE_LEN)
  ) u_tile_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .load_i      (start_acc),
    .len_i       (len_i),
    .sub_i       (tc_sub),
    .sub_len_i   (tile_len_q),
    .tile_len_o  (tc_tile_len),
    .last_tile_o (tc_last)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    tile_len_d  = tile_len_q;
    addr_d      = addr_q;
    sclr_d      = 1'b0;
    req_start_o = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          sclr_d  = 1'b1;
          state_d = (len_i == '0) ? ST_DONE : ST_PREP;
        end
      end
      ST_PREP: begin
        tile_len_d = tc_tile_len;
        mask_d     = '0;
        state_d    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (&ready_start_i) begin
          req_start_o = '1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mask_d = mask_q | done_i;
        if (&mask_d) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Byte addresses advance by four per word and wrap silently.
        for (int ch = 0; ch < NCH; ch++) begin
          addr_d[ch] = addr_q[ch] + AW'({tile_len_q, 2'b00});
        end
        state_d = tc_last ? ST_DONE : ST_PREP;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_i) begin
      state_d     = ST_IDLE;
      mask_d      = '0;
      tile_len_d  = '0;
      addr_d      = '0;
      sclr_d      = 1'b0;
      req_start_o = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      tile_len_q <= '0;
      addr_q     <= '0;
      sclr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      tile_len_q <= tile_len_d;
      addr_q     <= addr_d;
      sclr_q     <= sclr_d;
    end
  end

  assign addr_o           = addr_q;
  assign tile_len_o       = tile_len_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign streamer_clear_o = sclr_q;
  assign dbg_state_o      = state_q;

`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_busy_d  = perf_busy_q;
    perf_stall_d = perf_stall_q;
    if (clear_i || start_acc) begin
      perf_busy_d  = '0;
      perf_stall_d = '0;
    end else begin
      if (busy_o && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_d = perf_busy_q + 32'd1;
      end
      if ((state_q == ST_ISSUE) && !(&ready_start_i) && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_stall_cycles_o = perf_stall_q;
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_actuator_stream_ctrl.sv
// Scoreboard bench for actuator_stream_ctrl: expected tiles are queued per job
// and compared whenever the DUT issues a start request or completes a job.
module tb_actuator_stream_ctrl;
  import actuator_package::*;

  localparam int TILE  = 64;
  localparam int EXP_W = 4 * 32 + 16;

  logic         clk;
  logic         rst_i;
  logic         clear_i;
  logic         start_i;
  logic [15:0]  len_i;
  logic [127:0] base_addr_i;
  logic [3:0]   ready_start_i;
  logic [3:0]   done_i;
  logic [3:0]   req_start_o;
  logic [127:0] addr_o;
  logic [15:0]  tile_len_o;
  logic         busy_o;
  logic         done_o;
  logic         streamer_clear_o;
  logic [2:0]   dbg_state_o;
`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
  logic [31:0]  perf_busy_cycles_o;
  logic [31:0]  perf_stall_cycles_o;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int               done_exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               req_cnt  = 0;

  actuator_stream_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .start_i          (start_i),
    .len_i            (len_i),
    .base_addr_i      (base_addr_i),
    .ready_start_i    (ready_start_i),
    .done_i           (done_i),
    .req_start_o      (req_start_o),
    .addr_o           (addr_o),
    .tile_len_o       (tile_len_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .streamer_clear_o (streamer_clear_o),
    .dbg_state_o      (dbg_state_o)
`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
    ,
    .perf_busy_cycles_o  (perf_busy_cycles_o),
    .perf_stall_cycles_o (perf_stall_cycles_o)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard side: compare every start request and every job completion.
  always @(negedge clk) begin
    if (rst_i || clear_i) begin
      req_cnt = 0;
    end else begin
      if (req_start_o != 4'h0) begin
        check_eq("req_all", req_start_o, 4'hF);
        check_eq("req_ready", ready_start_i, 4'hF);
        if (exp_q.size() == 0) begin
          check_eq("req_unexpected", req_start_o, 4'h0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          for (int c = 0; c < 4; c++) begin
            check_eq($sformatf("addr_ch%0d", c), addr_o[c*32 +: 32], e[16 + c*32 +: 32]);
          end
          check_eq("tile_len", tile_len_o, e[15:0]);
        end
        req_cnt++;
      end
      if (done_o) begin
        if (done_exp_q.size() == 0) begin
          check_eq("done_unexpected", done_o, 1'b0);
        end else begin
          check_eq("done_tiles", req_cnt, done_exp_q.pop_front());
        end
        req_cnt = 0;
      end
    end
  end

  // Driver tasks
  task automatic push_model(input logic [15:0] len, input logic [127:0] bases, output int nt);
    logic [31:0] a[4];
    int rem;
    int tl;
    for (int c = 0; c < 4; c++) a[c] = bases[c*32 +: 32];
    rem = int'(len);
    nt  = 0;
    while (rem > 0) begin
      tl = (rem > TILE) ? TILE : rem;
      exp_q.push_back({a[3], a[2], a[1], a[0], 16'(tl)});
      for (int c = 0; c < 4; c++) a[c] = a[c] + 32'(tl * 4);
      rem = rem - tl;
      nt++;
    end
    done_exp_q.push_back(nt);
  endtask

  task automatic start_job(input logic [15:0] len, input logic [127:0] bases);
    @(posedge clk); #1;
    start_i     = 1'b1;
    len_i       = len;
    base_addr_i = bases;
    @(negedge clk);
    check_eq("busy_before", busy_o, 1'b0);
    @(posedge clk); #1;
    start_i     = 1'b0;
    len_i       = 16'($urandom);
    base_addr_i = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check_eq("busy_start", busy_o, 1'b1);
    check_eq("sclr_start", streamer_clear_o, 1'b1);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_start_o == 4'h0 && n < 100);
    check_eq("req_seen", req_start_o, 4'hF);
  endtask

  task automatic stall_issue();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state_o != ST_ISSUE && n < 50);
    check_eq("reach_issue", dbg_state_o, ST_ISSUE);
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      done_i = (k == 3) ? 4'hF : 4'h0;
      @(negedge clk);
      check_eq("stall_hold", req_start_o, 4'h0);
    end
    @(posedge clk); #1;
    done_i        = 4'h0;
    ready_start_i = 4'hF;
    @(negedge clk);
    check_eq("stall_release", req_start_o, 4'hF);
`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
    check_eq("perf_stall", perf_stall_cycles_o, 32'd10);
`endif
  endtask

  task automatic finish_tile(input bit serial, input bit last);
    int ord[5];
    ord = '{3, 0, 0, 2, 1};
    if (serial) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        done_i = 4'(1 << ord[i]);
        @(negedge clk);
        check_eq("wait_hold", dbg_state_o, ST_WAIT);
      end
    end else begin
      @(posedge clk); #1;
      done_i = 4'hF;
      @(negedge clk);
    end
    @(posedge clk); #1;
    done_i = 4'h0;
    @(negedge clk);
    check_eq("enter_next", dbg_state_o, ST_NEXT);
    @(negedge clk);
    check_eq("done_lat", done_o, last);
    check_eq("after_next", dbg_state_o, last ? ST_DONE : ST_PREP);
  endtask

  task automatic run_job(input logic [15:0] len, input logic [127:0] bases,
                         input bit serial, input bit stall, input bit ign_start);
    int nt;
    push_model(len, bases, nt);
    if (stall) ready_start_i = 4'b1011;
    start_job(len, bases);
    if (nt == 0) begin
      check_eq("len0_done", done_o, 1'b1);
      @(negedge clk);
      check_eq("len0_busy_end", busy_o, 1'b0);
      check_eq("len0_done_end", done_o, 1'b0);
      return;
    end
    for (int t = 0; t < nt; t++) begin
      if (stall && t == 0) stall_issue();
      else wait_req();
      if (ign_start && t == 0) begin
        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = 16'd5;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check_eq("ign_start_sclr", streamer_clear_o, 1'b0);
      end
      finish_tile(serial, t == nt - 1);
    end
    @(negedge clk);
    check_eq("busy_end", busy_o, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_done"}, done_o, 1'b0);
    check_eq({tag, "_sclr"}, streamer_clear_o, 1'b0);
    check_eq({tag, "_req"}, req_start_o, 4'h0);
    check_eq({tag, "_addr_lo"}, addr_o[63:0], 64'h0);
    check_eq({tag, "_addr_hi"}, addr_o[127:64], 64'h0);
    check_eq({tag, "_tlen"}, tile_len_o, 16'h0);
    check_eq({tag, "_state"}, dbg_state_o, ST_IDLE);
  endtask

  initial begin
    int nt;
    rst_i         = 1'b1;
    clear_i       = 1'b0;
    start_i       = 1'b0;
    len_i         = '0;
    base_addr_i   = '0;
    ready_start_i = 4'hF;
    done_i        = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_job(16'd150, {32'h4000, 32'h3000, 32'h2000, 32'h1000}, 1'b0, 1'b0, 1'b1);
    run_job(16'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);
`ifdef ACTUATOR_STREAM_CTRL_PERF_EN
    check_eq("perf_busy_len0", perf_busy_cycles_o, 32'd1);
`endif
    run_job(16'd100, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    run_job(16'd100, {$urandom, $urandom, $urandom, 32'hFFFF_FFF0}, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      run_job(16'($urandom_range(1, 300)), {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Asynchronous reset while waiting for done, with a done pulse in flight.
    push_model(16'd150, {$urandom, $urandom, $urandom, $urandom}, nt);
    start_job(16'd150, exp_q[0][143:16]);
    wait_req();
    @(posedge clk); #1;
    done_i = 4'b0001;
    #2 rst_i = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk); #1;
    done_i = 4'h0;
    rst_i  = 1'b0;
    exp_q.delete();
    done_exp_q.delete();
    run_job(16'd70, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0);

    // Synchronous clear while stuck in ISSUE.
    ready_start_i = 4'b1011;
    push_model(16'd40, {$urandom, $urandom, $urandom, $urandom}, nt);
    start_job(16'd40, exp_q[0][143:16]);
    @(negedge clk);
    check_eq("clr_in_issue", dbg_state_o, ST_ISSUE);
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i       = 1'b0;
    ready_start_i = 4'hF;
    @(negedge clk);
    check_zero("clear");
    exp_q.delete();
    done_exp_q.delete();
    run_job(16'd64, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("done_q_empty", done_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
